// File: rtl/mem_axi_pkg.sv
// Shared types and AXI encodings for mem_axi_bridge.
package mem_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_BYTE  = 3'b000;
  localparam logic [2:0] AXI_SIZE_HALF  = 3'b001;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

endpackage

// File: rtl/mem_axi_bridge.sv
// Single-outstanding, single-beat bridge from the cache memory port to AXI.
// Optional: define AXI_ERR_CHK_EN to add a sticky bus_err output.
module mem_axi_bridge
  import mem_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [3:0]  AXI_ID = 4'b0000
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef AXI_ERR_CHK_EN
  output logic                  bus_err,
`endif
  input  logic [ADDR_W-1:0]     mem_a,
  input  logic                  mem_access,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic [DATA_W/8-1:0]   mem_sel,
  input  logic [DATA_W-1:0]     mem_st_data,
  output logic                  mem_ready,
  output logic [DATA_W-1:0]     mem_data,
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  state_t                state, state_n;
  logic                  latch_en;
  logic                  aw_done, aw_done_n;
  logic                  w_done, w_done_n;
  logic [ADDR_W-1:0]     addr_q;
  logic [1:0]            size_q;
  logic [DATA_W/8-1:0]   sel_q;
  logic [DATA_W-1:0]     data_q;
  logic                  write_q;

  // Fixed single-beat INCR attributes.
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = AXI_ID;
  assign awlen   = 4'd0;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = AXI_ID;
  assign wlast   = 1'b1;

  // Address/data channels always come from the request latched in IDLE.
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arsize = 3'(size_q);
  assign awsize = 3'(size_q);
  assign wdata  = data_q;
  assign wstrb  = sel_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; AW and W completion tracked independently in WR.
  always_comb begin
    state_n   = state;
    latch_en  = 1'b0;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    case (state)
      IDLE: begin
        if (mem_access) begin
          latch_en  = 1'b1;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = mem_write ? WR : RD_ADDR;
        end
      end
      RD_ADDR: if (arvalid && arready) state_n = RD_DATA;
      RD_DATA: if (rready && rvalid)   state_n = DONE;
      WR: begin
        if (awvalid && awready) aw_done_n = 1'b1;
        if (wvalid && wready)   w_done_n  = 1'b1;
        if (aw_done_n && w_done_n) state_n = WR_RESP;
      end
      WR_RESP: if (bready && bvalid) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered handshake outputs, request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      mem_ready <= 1'b0;
      mem_data  <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      sel_q     <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
    end else begin
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      arvalid   <= (state_n == RD_ADDR);
      rready    <= (state_n == RD_DATA);
      awvalid   <= (state_n == WR) && !aw_done_n;
      wvalid    <= (state_n == WR) && !w_done_n;
      bready    <= (state_n == WR_RESP);
      mem_ready <= (state_n == DONE);
      if (latch_en) begin
        addr_q  <= mem_a;
        size_q  <= mem_size;
        sel_q   <= mem_sel;
        data_q  <= mem_st_data;
        write_q <= mem_write;
      end
      if (state == RD_DATA && rready && rvalid) mem_data <= rdata;
    end
  end

`ifdef AXI_ERR_CHK_EN
  // Sticky error flag on any non-OKAY response at its handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if ((state == RD_DATA && rready && rvalid && rresp != RESP_OKAY) ||
                 (state == WR_RESP && bready && bvalid && bresp != RESP_OKAY)) begin
      bus_err <= 1'b1;
    end
  end

  logic unused_resp;
  assign unused_resp = ^{rid, rlast, bid, write_q};
`else
  logic unused_resp;
  assign unused_resp = ^{rid, rlast, bid, rresp, bresp, write_q};
`endif

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed self-checking bench for mem_axi_bridge with a delay-programmable AXI slave.
module tb_mem_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_a = '0;
  logic        mem_access = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_st_data = '0;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen;
  logic [3:0]  awlen, arcache, awcache, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst;
  logic        arlock, awlock, arvalid, awvalid, wvalid, wlast, rready, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic        rlast = 1'b1;
  logic [3:0]  rid = '0, bid = '0;
`ifdef AXI_ERR_CHK_EN
  logic        bus_err;
`endif

  int checks = 0;
  int failures = 0;

  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int ar_hs, r_hs, aw_hs, w_hs, b_hs, bready_cyc, ready_cnt;
  bit w_first;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [2:0]  last_arsize, last_awsize;
  logic [3:0]  last_wstrb;

  mem_axi_bridge dut (
    .clk(clk), .rst(rst),
`ifdef AXI_ERR_CHK_EN
    .bus_err(bus_err),
`endif
    .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Slave: each ready/valid rises once its partner has been waiting the programmed cycles.
  always @(negedge clk) begin
    if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
    else begin arready = 1'b0; ar_cnt = 0; end
    if (rready) begin rvalid = (r_cnt >= r_dly); r_cnt++; end
    else begin rvalid = 1'b0; r_cnt = 0; end
    if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
    else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
    else begin wready = 1'b0; w_cnt = 0; end
    if (bready) begin bvalid = (b_cnt >= b_dly); b_cnt++; end
    else begin bvalid = 1'b0; b_cnt = 0; end
  end

  // Handshake monitor.
  always @(posedge clk) begin
    if (arvalid && arready) begin ar_hs++; last_araddr = araddr; last_arsize = arsize; end
    if (rvalid && rready) r_hs++;
    if (awvalid && awready) begin aw_hs++; last_awaddr = awaddr; last_awsize = awsize; end
    if (wvalid && wready) begin w_hs++; last_wdata = wdata; last_wstrb = wstrb; end
    if (bvalid && bready) b_hs++;
    if (bready) bready_cyc++;
    if (awvalid && !wvalid) w_first = 1'b1;
    if (mem_ready) ready_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr_stats();
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    bready_cyc = 0; ready_cnt = 0; w_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request; lat counts cycles from the accepting IDLE cycle to the mem_ready cycle.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic [3:0] sel, input logic [31:0] d, input bit hold,
                        output int lat);
    int edges;
    bit got;
    @(negedge clk);
    mem_write = wr; mem_a = a; mem_size = sz; mem_sel = sel; mem_st_data = d;
    mem_access = 1'b1;
    edges = 0; got = 1'b0;
    while (!got && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (mem_ready) got = 1'b1;
    end
    check("req_done", 64'(got), 64'd1);
    lat = edges + 1;
    if (!hold) begin
      @(negedge clk);
      mem_access = 1'b0;
    end
  endtask

  initial begin
    int lat;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_mem_ready", 64'(mem_ready), 64'd0);
    check("rst_mem_data", 64'(mem_data), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Zero-wait word read.
    clr_stats();
    rdata = 32'h3C1D_BFC0;
    do_req(1'b0, 32'hBFC0_0000, 2'b10, 4'hF, 32'h0, 1'b0, lat);
    check("rd_lat", 64'(lat), 64'd4);
    check("rd_data", 64'(mem_data), 64'h3C1D_BFC0);
    check("rd_arsize", 64'(last_arsize), 64'd2);
    check("rd_araddr", 64'(last_araddr), 64'hBFC0_0000);
    check("rd_arlen", 64'(arlen), 64'd0);
    check("rd_arburst", 64'(arburst), 64'd1);
    idle(3);
    check("rd_ar_hs", 64'(ar_hs), 64'd1);
    check("rd_ready_cnt", 64'(ready_cnt), 64'd1);

    // Byte write, W accepted three cycles ahead of AW.
    clr_stats();
    aw_dly = 4; w_dly = 1; b_dly = 0;
    do_req(1'b1, 32'h8000_1003, 2'b00, 4'b1000, 32'hAB00_0000, 1'b0, lat);
    check("bw_lat", 64'(lat), 64'd8);
    idle(3);
    check("bw_awaddr", 64'(last_awaddr), 64'h8000_1003);
    check("bw_awsize", 64'(last_awsize), 64'd0);
    check("bw_wdata", 64'(last_wdata), 64'hAB00_0000);
    check("bw_wstrb", 64'(last_wstrb), 64'h8);
    check("bw_aw_held", 64'(w_first), 64'd1);
    check("bw_aw_hs", 64'(aw_hs), 64'd1);
    check("bw_w_hs", 64'(w_hs), 64'd1);
    check("bw_b_hs", 64'(b_hs), 64'd1);
    check("bw_ready_cnt", 64'(ready_cnt), 64'd1);
    check("bw_wlast", 64'(wlast), 64'd1);
    check("bw_mem_data_kept", 64'(mem_data), 64'h3C1D_BFC0);

    // Same-cycle AW/W, slow write response.
    clr_stats();
    aw_dly = 0; w_dly = 0; b_dly = 5;
    do_req(1'b1, 32'h8000_2000, 2'b10, 4'hF, 32'h1234_5678, 1'b0, lat);
    check("sw_lat", 64'(lat), 64'd9);
    idle(3);
    check("sw_bready_cyc", 64'(bready_cyc), 64'd6);
    check("sw_b_hs", 64'(b_hs), 64'd1);
    check("sw_ready_cnt", 64'(ready_cnt), 64'd1);
    check("sw_w_first", 64'(w_first), 64'd0);

    // Zero-wait write latency.
    clr_stats();
    b_dly = 0;
    do_req(1'b1, 32'h8000_3000, 2'b01, 4'b0011, 32'h0000_BEEF, 1'b0, lat);
    check("zw_lat", 64'(lat), 64'd4);
    check("zw_awsize", 64'(last_awsize), 64'd1);

    // mem_access held high through and past mem_ready.
    idle(2);
    clr_stats();
    rdata = 32'h1122_3344;
    do_req(1'b0, 32'h0000_0040, 2'b10, 4'hF, 32'h0, 1'b1, lat);
    idle(1);
    check("hold_no_relaunch", 64'(arvalid), 64'd0);
    @(negedge clk);
    mem_access = 1'b0;
    idle(5);
    check("hold_ar_hs", 64'(ar_hs), 64'd1);
    check("hold_ready_cnt", 64'(ready_cnt), 64'd1);
    rdata = 32'h5566_7788;
    do_req(1'b0, 32'h0000_0044, 2'b10, 4'hF, 32'h0, 1'b0, lat);
    check("next_lat", 64'(lat), 64'd4);
    check("next_data", 64'(mem_data), 64'h5566_7788);

    // arready stalled while live request inputs change underneath.
    idle(2);
    clr_stats();
    ar_dly = 10;
    rdata = 32'hCAFE_F00D;
    fork
      do_req(1'b0, 32'h1000_0000, 2'b10, 4'hF, 32'h0, 1'b0, lat);
      begin
        repeat (4) @(negedge clk);
        mem_a = 32'hDEAD_BEEC; mem_size = 2'b00; mem_write = 1'b1;
        @(posedge clk); #1;
        check("stall_araddr_live", 64'(araddr), 64'h1000_0000);
        check("stall_arvalid", 64'(arvalid), 64'd1);
      end
    join
    check("stall_lat", 64'(lat), 64'd14);
    check("stall_araddr_hs", 64'(last_araddr), 64'h1000_0000);
    check("stall_arsize_hs", 64'(last_arsize), 64'd2);
    check("stall_data", 64'(mem_data), 64'hCAFE_F00D);
    idle(3);
    check("stall_no_aw", 64'(aw_hs), 64'd0);
    ar_dly = 0;
    mem_write = 1'b0;

`ifdef AXI_ERR_CHK_EN
    check("err_clear", 64'(bus_err), 64'd0);
    rresp = 2'b10;
    rdata = 32'h0BAD_0BAD;
    do_req(1'b0, 32'h2000_0000, 2'b10, 4'hF, 32'h0, 1'b0, lat);
    check("err_rd_done_lat", 64'(lat), 64'd4);
    idle(1);
    check("err_set", 64'(bus_err), 64'd1);
    rresp = 2'b00;
    do_req(1'b0, 32'h2000_0004, 2'b10, 4'hF, 32'h0, 1'b0, lat);
    idle(1);
    check("err_sticky", 64'(bus_err), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    check("err_rst", 64'(bus_err), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_axi_bridge.md
Name: mem_axi_bridge

Overview:
Single-outstanding, single-beat bridge from the cache-side memory port to AXI4 master channels. It sits directly downstream of the i_cache/d_cache request mux in mycpu_top and receives the muxed request. Reads and writes run as one beat each (arlen/awlen=0), and completion is signalled on a one-cycle mem_ready pulse. One transaction is in flight at a time, so there is no ID reordering.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; fixed at 32, wstrb is 4 bits
AXI_ID, 4'b0000, constant value driven on arid/awid/wid

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
mem_a  in  32  request byte address
mem_access  in  1  request valid; held high until mem_ready
mem_write  in  1  0 = read, 1 = write
mem_size  in  2  00 = byte, 01 = half, 10 = word; drives arsize/awsize
mem_sel  in  4  byte strobes for writes
mem_st_data  in  32  write data
mem_ready  out  1  one-cycle completion pulse
mem_data  out  32  read data; valid with mem_ready and held until next read completes
arid/araddr/arlen(8)/arsize/arburst/arlock/arcache/arprot/arvalid  out  per AXI4  read address channel
arready  in  1  read address ready
rid/rdata/rresp/rlast/rvalid  in  per AXI4  read data channel
rready  out  1  read data ready
awid/awaddr/awlen(4)/awsize/awburst/awlock/awcache/awprot/awvalid  out  per AXI4  write address channel
awready  in  1  write address ready
wid/wdata/wstrb/wlast/wvalid  out  per AXI4  write data channel
wready  in  1  write data ready
bid/bresp/bvalid  in  per AXI4  write response channel
bready  out  1  write response ready

Behaviour:
- Constants: arlen = awlen = 0, arburst = awburst = 2'b01, lock/cache/prot = 0, wlast = 1, IDs = AXI_ID.
- States: IDLE, RD_ADDR, RD_DATA, WR (AW and W in parallel), WR_RESP, DONE.
- IDLE: if mem_access, latch mem_a/size/sel/st_data/write into internal regs. mem_write = 0 -> RD_ADDR; mem_write = 1 -> WR.
- All AXI outputs are driven from the latched regs, never from live inputs.
- RD_ADDR: arvalid = 1. On arready -> RD_DATA. arvalid drops the cycle after the handshake.
- RD_DATA: rready = 1. On rvalid, capture rdata into mem_data -> DONE.
- WR: awvalid and wvalid rise together; each is tracked by its own done flag and deasserts after its own handshake.
- WR: when both done flags are set, or both handshakes land in the same cycle -> WR_RESP. AW accepted before W, or W before AW, must both work.
- WR_RESP: bready = 1. On bvalid -> DONE.
- DONE: mem_ready = 1 for exactly one cycle -> IDLE. mem_access is ignored in DONE, so a strobe still held high after ready does not launch a duplicate request.
- Latency: minimum read is 4 cycles from request acceptance to mem_ready (IDLE, RD_ADDR, RD_DATA, DONE) with zero-wait slave. Minimum write is 4 cycles.
- rresp/bresp/rid/bid/rlast are ignored by default.
- Reset values: all valid/ready outputs 0, mem_ready 0, mem_data 0, latched regs 0, state IDLE.
- Reset mid-transaction drops all valids next cycle. The bench must not issue rst mid-burst against a strict AXI checker.
- Live-input changes during a transaction have no effect.

Optional Feature:
AXI_ERR_CHK_EN.
- Defined: adds output bus_err (1 bit, sticky, cleared only by rst). It is set when rresp or bresp is non-zero at the response handshake. Completion still occurs normally.
- Undefined: no port, resp fields unused.

Decomposition:
- Package mem_axi_pkg: state enum, AXI_BURST_INCR = 2'b01, AXI_SIZE_* constants, RESP_OKAY = 2'b00.
- Single module is sufficient. The natural sub-module, if split, is mem_axi_wr_ctrl, owning the AW/W done flags and WR/WR_RESP sequencing.

Test Plan:
- Word read 0xBFC00000, arready/rvalid immediate, rdata = 0x3C1DBFC0 -> arsize = 2, mem_ready at cycle 4, mem_data = 0x3C1DBFC0.
- Byte write 0x80001003, sel = 4'b1000, data 0xAB000000; wready 3 cycles before awready -> awvalid held until its handshake, a single bready handshake, one mem_ready.
- AW and W accepted in the same cycle, bvalid delayed 5 cycles -> WR_RESP holds bready, mem_ready exactly once.
- mem_access held high through and after mem_ready -> exactly one AR per request, the next request starts from IDLE after DONE.
- arready stalled 10 cycles, then araddr changes on the input -> araddr on the bus stays at the latched value.
- AXI_ERR_CHK_EN defined, rresp = 2'b10 -> bus_err = 1 and remains set until rst.
